hp_bar_updater: RTL
===================

HP_BAR_UPDATER -- requirements
Module: hp_bar_updater

Interface
REQ-001 SHALL have parameter MAX_HP, default 48, meaning full HP and the interior bar width in pixels.
REQ-002 SHALL have parameter BAR_H, default 4, meaning the interior bar height in pixels.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all registers sample on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests one update-and-redraw; sampled only in IDLE.
REQ-006 SHALL have port refill, input, 1 bit: sampled with start; when 1, HP is set to MAX_HP and damage is ignored.
REQ-007 SHALL have port damage, input, 6 bits: HP to subtract, sampled with start.
REQ-008 SHALL have port base_x, input, 9 bits: bar top-left x, sampled with start.
REQ-009 SHALL have port base_y, input, 8 bits: bar top-left y, sampled with start.
REQ-010 SHALL have port out_x, output, 9 bits: pixel x, for the VGA x mux.
REQ-011 SHALL have port out_y, output, 8 bits: pixel y, for the VGA y mux.
REQ-012 SHALL have port out_colour, output, 3 bits: pixel colour, for the colour mux.
REQ-013 SHALL have port plot, output, 1 bit: high exactly while a valid pixel is presented.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last pixel.
REQ-016 SHALL have port hp, output, 6 bits: current HP.
REQ-017 SHALL have port fainted, output, 1 bit: high when hp == 0.

Function
REQ-018 SHALL implement the FSM states IDLE, SUB, DRAW and DONE, with transitions IDLE->SUB on start, SUB->DRAW unconditionally, DRAW->DONE after the last pixel, and DONE->IDLE unconditionally.
REQ-019 SHALL, on accepting start, latch damage, refill, base_x and base_y, and ignore start in every state other than IDLE.
REQ-020 SHALL, at the end of SUB, update hp as follows: refill gives MAX_HP; otherwise hp - damage, saturated at 0 with no wrap.
REQ-021 SHALL, in DRAW, raster-scan (MAX_HP+2) x (BAR_H+2) pixels row-major starting at (0,0), one pixel per cycle: 300 cycles at the default parameters.
REQ-022 SHALL drive out_x = base_x + col and out_y = base_y + row, with sums truncated to the port widths; keeping the bar on screen (base_x <= 270, base_y <= 234) is the caller's responsibility.
REQ-023 SHALL colour every pixel with row or col on the outer edge 3'b000 (black border).
REQ-024 SHALL colour each interior pixel at column c (1..MAX_HP) with the fill colour when c <= hp, and 3'b111 otherwise.
REQ-025 SHALL select the fill colour from the updated hp: 3'b010 when hp > MAX_HP/2, 3'b110 when MAX_HP/4 < hp <= MAX_HP/2, and 3'b100 when hp <= MAX_HP/4.
REQ-026 SHALL assert plot only in DRAW, with plot asserted for exactly (MAX_HP+2)*(BAR_H+2) cycles per update.
REQ-027 SHALL meet this timing, with start sampled in cycle 0: SUB in cycle 1, pixels in cycles 2..301, done in cycle 302, IDLE from cycle 303.
REQ-028 SHALL accept a start issued in the cycle after done.
REQ-029 SHALL treat damage = 0 with refill = 0 as a pure redraw that leaves hp unchanged.

Reset
REQ-030 SHALL, on reset assertion, immediately drive state IDLE, hp = MAX_HP, fainted = 0, raster counters = 0, latched inputs = 0, and plot = busy = done = 0, with out_x, out_y and out_colour at 0.
REQ-031 SHALL, on reset during any active state, abort the operation with no done pulse and no further plot.

Structure
REQ-032 SHALL place the state encoding, the colour codes (BLACK, WHITE, GREEN, YELLOW, RED) and the default MAX_HP and BAR_H in the shared package battle_pkg.
REQ-033 SHALL use a single sub-module raster_scan: a col/row counter with enable and clear, providing a last-pixel flag.

Verification
REQ-034 SHALL be tested with: reset, then start with damage=0 at base (179,115) -> 300 plots; pixel (179,115)=000; pixel (180,116)=010; done in cycle 302; hp=48.
REQ-035 SHALL be tested with: damage=30 from hp=48 -> hp=18; pixel x=base+18 interior = 110; pixel x=base+19 interior = 111.
REQ-036 SHALL be tested with: damage=25 from hp=18 -> hp=0; fainted=1; all interior pixels 111; border 000.
REQ-037 SHALL be tested with: a second start in cycle 100 of a busy operation -> single done pulse; hp decremented once only.
REQ-038 SHALL be tested with: reset asserted in cycle 150 -> plot=0 at once; no done; hp=48.
REQ-039 SHALL be tested with: refill=1, damage=40 after faint -> hp=48; fainted=0; interior fully 010.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and constants for the battle HUD blocks: FSM encoding,
// bar colour codes, default bar geometry and the HP fill-colour rule.
package battle_pkg;

  localparam int unsigned HP_W       = 6;
  localparam int unsigned X_W        = 9;
  localparam int unsigned Y_W        = 8;
  localparam int unsigned COLOUR_W   = 3;

  localparam int unsigned MAX_HP_DEF = 48;
  localparam int unsigned BAR_H_DEF  = 4;

  localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE  = 3'b111;
  localparam logic [COLOUR_W-1:0] GREEN  = 3'b010;
  localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;
  localparam logic [COLOUR_W-1:0] RED    = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  // Fill colour of the bar for a given HP: green above half, yellow above a quarter, red otherwise.
  function automatic logic [COLOUR_W-1:0] fill_colour(input logic [HP_W-1:0] hp,
                                                      input int unsigned max_hp);
    if (32'(hp) > max_hp / 2)      return GREEN;
    else if (32'(hp) > max_hp / 4) return YELLOW;
    else                           return RED;
  endfunction

endpackage

// File: rtl/raster_scan.sv
// Row-major col/row raster counter.
// Ports: clock, reset (async, active-high), en (advance one pixel),
//        clear (sync return to (0,0), wins over en), col, row (current pixel),
//        last_c (combinational: current pixel is the final one).
module raster_scan
  import battle_pkg::*;
#(
  parameter int unsigned COLS  = MAX_HP_DEF + 2,
  parameter int unsigned ROWS  = BAR_H_DEF + 2,
  parameter int unsigned COL_W = $clog2(COLS),
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_c
);

  logic col_end_c;
  logic row_end_c;

  assign col_end_c = (col == COL_W'(COLS - 1));
  assign row_end_c = (row == ROW_W'(ROWS - 1));
  assign last_c    = col_end_c && row_end_c;

  // Advancing past the last pixel wraps back to (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end_c) begin
        col <= '0;
        row <= row_end_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/hp_bar_updater.sv
// Applies damage/refill to the HP register, then redraws the HP bar
// (black border, fill up to hp, white remainder) one pixel per cycle.
// Ports: clock, reset (async, active-high); start/refill/damage/base_x/base_y
//        command inputs sampled in IDLE; out_x/out_y/out_colour/plot pixel
//        stream; busy, done (one-cycle pulse), hp, fainted status.
module hp_bar_updater
  import battle_pkg::*;
#(
  parameter int unsigned MAX_HP = MAX_HP_DEF,
  parameter int unsigned BAR_H  = BAR_H_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                refill,
  input  logic [HP_W-1:0]     damage,
  input  logic [X_W-1:0]      base_x,
  input  logic [Y_W-1:0]      base_y,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [HP_W-1:0]     hp,
  output logic                fainted
);

  localparam int unsigned COLS  = MAX_HP + 2;
  localparam int unsigned ROWS  = BAR_H + 2;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  state_t state;
  state_t state_next;

  logic                refill_q;
  logic [HP_W-1:0]     damage_q;
  logic [X_W-1:0]      base_x_q;
  logic [Y_W-1:0]      base_y_q;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                last_c;
  logic                out_last;

  logic                scan_en_c;
  logic                scan_clear_c;
  logic [HP_W-1:0]     hp_new_c;
  logic [HP_W-1:0]     hp_draw_c;
  logic                border_c;
  logic [COLOUR_W-1:0] colour_c;

  // The counter always points at the pixel to be presented next.
  assign scan_en_c    = (state_next == DRAW);
  assign scan_clear_c = (state == IDLE) || (state == DONE);

  raster_scan #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .en     (scan_en_c),
    .clear  (scan_clear_c),
    .col    (col),
    .row    (row),
    .last_c (last_c)
  );

  // Saturating HP update from the latched command.
  always_comb begin
    hp_new_c = hp;
    if (refill_q)           hp_new_c = HP_W'(MAX_HP);
    else if (damage_q >= hp) hp_new_c = '0;
    else                    hp_new_c = hp - damage_q;
  end

  // Pixel (0,0) is registered at the end of SUB, before hp itself updates.
  assign hp_draw_c = (state == SUB) ? hp_new_c : hp;

  assign border_c = (col == '0) || (col == COL_W'(COLS - 1)) ||
                    (row == '0) || (row == ROW_W'(ROWS - 1));

  always_comb begin
    colour_c = BLACK;
    if (!border_c) begin
      colour_c = (32'(col) <= 32'(hp_draw_c)) ? fill_colour(hp_draw_c, MAX_HP) : WHITE;
    end
  end

  // Next-state logic; DRAW ends once the final pixel has been presented.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SUB;
      SUB:     state_next = DRAW;
      DRAW:    if (out_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Command latch and HP register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refill_q <= 1'b0;
      damage_q <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      hp       <= HP_W'(MAX_HP);
      fainted  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        refill_q <= refill;
        damage_q <= damage;
        base_x_q <= base_x;
        base_y_q <= base_y;
      end
      if (state == SUB) begin
        hp      <= hp_new_c;
        fainted <= (hp_new_c == '0);
      end
    end
  end

  // Registered pixel stream and status, timed to the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= BLACK;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      plot <= (state_next == DRAW);
      if (state_next == DRAW) begin
        out_x      <= base_x_q + X_W'(col);
        out_y      <= base_y_q + Y_W'(row);
        out_colour <= colour_c;
        out_last   <= last_c;
      end else begin
        out_x      <= '0;
        out_y      <= '0;
        out_colour <= BLACK;
        out_last   <= 1'b0;
      end
    end
  end

endmodule
